// File: rtl/data_sync_pkg.sv
// Shared definitions for the multi-channel data synchronizer.
//   EN_MODE_LEVEL / EN_MODE_TOGGLE : enable interpretation selectors
//   ch_idx_width()                 : width of a channel index (clog2, minimum 1)
package data_sync_pkg;

  localparam int EN_MODE_LEVEL  = 0;
  localparam int EN_MODE_TOGGLE = 1;

  function automatic int ch_idx_width(input int num_ch);
    if (num_ch <= 1) begin
      return 1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One source channel: enable synchronizer, edge detector, hold register,
// pending flag and sticky overrun flag.
// Ports:
//   clk, rst      : destination clock, async active-high reset
//   bus           : channel source data (stable from enable change to capture)
//   enable        : asynchronous channel enable (level or toggle)
//   grant         : arbiter takes this channel's held word at this edge
//   ovr_clr       : synchronous clear of ovr_flag
//   enable_pulse  : registered one-cycle event strobe
//   hold          : captured word
//   pend          : hold contains a word not yet granted
//   ovr_flag      : sticky overrun (an event arrived while a word was pending)
module data_sync_ch #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int EN_MODE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] bus,
  input  logic                 enable,
  input  logic                 grant,
  input  logic                 ovr_clr,
  output logic                 enable_pulse,
  output logic [BUS_WIDTH-1:0] hold,
  output logic                 pend,
  output logic                 ovr_flag
);
  import data_sync_pkg::*;

  logic [NUM_STAGES-1:0] sync_r;
  logic                  prev_r;
  logic                  evt_s;

  // Enable synchronizer chain and previous-value flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[NUM_STAGES-2:0], enable};
      prev_r <= sync_r[NUM_STAGES-1];
    end
  end

  // Event detection: rising edge in level mode, any edge in toggle mode.
  always_comb begin
    if (EN_MODE == EN_MODE_TOGGLE) begin
      evt_s = sync_r[NUM_STAGES-1] ^ prev_r;
    end else begin
      evt_s = sync_r[NUM_STAGES-1] & ~prev_r;
    end
  end

  // Capture, pending and overrun tracking. A granted word frees the hold
  // register at the same edge, so an event coinciding with its grant is
  // accepted rather than counted as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_pulse <= 1'b0;
      hold         <= '0;
      pend         <= 1'b0;
      ovr_flag     <= 1'b0;
    end else begin
      enable_pulse <= evt_s;
      if (evt_s && (!pend || grant)) begin
        hold <= bus;
      end
      if (evt_s) begin
        pend <= 1'b1;
      end else if (grant) begin
        pend <= 1'b0;
      end
      // Set has priority over a same-edge clear.
      if (evt_s && pend && !grant) begin
        ovr_flag <= 1'b1;
      end else if (ovr_clr) begin
        ovr_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel data synchronizer: NUM_CH channel front ends merged onto one
// valid/ready stream by a round-robin arbiter.
// Ports:
//   CLK, RST      : destination clock, async active-high reset
//   Unsync_bus    : channel c data at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable    : per-channel asynchronous enable
//   enable_pulse  : per-channel one-cycle event strobe
//   sync_bus      : output word
//   sync_ch       : source channel of sync_bus
//   sync_valid    : output word valid
//   sync_ready    : consumer accepts the word
//   ovr_flag      : sticky per-channel overrun
//   ovr_clr       : synchronous per-channel clear of ovr_flag
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int EN_MODE    = 0
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0]         Unsync_bus,
  input  logic [NUM_CH-1:0]                   bus_enable,
  output logic [NUM_CH-1:0]                   enable_pulse,
  output logic [BUS_WIDTH-1:0]                sync_bus,
  output logic [ch_idx_width(NUM_CH)-1:0]     sync_ch,
  output logic                                sync_valid,
  input  logic                                sync_ready,
  output logic [NUM_CH-1:0]                   ovr_flag,
  input  logic [NUM_CH-1:0]                   ovr_clr
);

  localparam int CH_W = ch_idx_width(NUM_CH);

  logic [NUM_CH-1:0][BUS_WIDTH-1:0] hold_s;
  logic [NUM_CH-1:0]                pend_s;
  logic [NUM_CH-1:0]                grant_s;
  logic                             free_s;
  logic                             gnt_found_s;
  logic [CH_W-1:0]                  gnt_idx_s;
  logic [CH_W-1:0]                  cand_s;
  logic [CH_W-1:0]                  last_grant_r;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_sync_ch #(
      .BUS_WIDTH  (BUS_WIDTH),
      .NUM_STAGES (NUM_STAGES),
      .EN_MODE    (EN_MODE)
    ) u_ch (
      .clk          (CLK),
      .rst          (RST),
      .bus          (Unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .enable       (bus_enable[c]),
      .grant        (grant_s[c]),
      .ovr_clr      (ovr_clr[c]),
      .enable_pulse (enable_pulse[c]),
      .hold         (hold_s[c]),
      .pend         (pend_s[c]),
      .ovr_flag     (ovr_flag[c])
    );
  end

  // Round-robin search: first pending channel upward from last_grant+1, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_s = CH_W'((int'(last_grant_r) + i) % NUM_CH);
      if (!gnt_found_s && pend_s[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Grant strobes: only issued when the output register can take a word.
  always_comb begin
    free_s  = !sync_valid || sync_ready;
    grant_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      grant_s[c] = free_s && gnt_found_s && (gnt_idx_s == CH_W'(c));
    end
  end

  // Output register; holds its word while stalled by sync_ready.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_valid   <= 1'b0;
      sync_bus     <= '0;
      sync_ch      <= '0;
      last_grant_r <= CH_W'(NUM_CH - 1);
    end else if (free_s) begin
      if (gnt_found_s) begin
        sync_valid   <= 1'b1;
        sync_bus     <= hold_s[gnt_idx_s];
        sync_ch      <= gnt_idx_s;
        last_grant_r <= gnt_idx_s;
      end else begin
        sync_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Self-checking bench for data_sync_mc (NUM_CH=4, BUS_WIDTH=8, NUM_STAGES=2).
// A level-mode and a toggle-mode instance share the clock and reset.
module tb_data_sync_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ubus, t_ubus;
  logic [3:0]  en, t_en, clr, t_clr;
  logic        rdy, t_rdy;
  logic [3:0]  pulse, t_pulse, ovr, t_ovr;
  logic [7:0]  dbus, t_dbus;
  logic [1:0]  ch, t_ch;
  logic        valid, t_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_CH(4), .BUS_WIDTH(8), .NUM_STAGES(2), .EN_MODE(0)) u_lvl (
    .CLK(CLK), .RST(RST), .Unsync_bus(ubus), .bus_enable(en),
    .enable_pulse(pulse), .sync_bus(dbus), .sync_ch(ch), .sync_valid(valid),
    .sync_ready(rdy), .ovr_flag(ovr), .ovr_clr(clr)
  );

  data_sync_mc #(.NUM_CH(4), .BUS_WIDTH(8), .NUM_STAGES(2), .EN_MODE(1)) u_tog (
    .CLK(CLK), .RST(RST), .Unsync_bus(t_ubus), .bus_enable(t_en),
    .enable_pulse(t_pulse), .sync_bus(t_dbus), .sync_ch(t_ch), .sync_valid(t_valid),
    .sync_ready(t_rdy), .ovr_flag(t_ovr), .ovr_clr(t_clr)
  );

  typedef struct {
    logic [3:0]  en;
    logic [31:0] bus;
    logic [3:0]  pulse;
    logic        valid;
    logic [7:0]  dbus;
    logic [1:0]  ch;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(input logic [3:0] e, input logic [31:0] b, input logic [3:0] p,
                              input logic v, input logic [7:0] d, input logic [1:0] c);
    vec_t r;
    r.en = e; r.bus = b; r.pulse = p; r.valid = v; r.dbus = d; r.ch = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Cycle-by-cycle table for the level-mode instance, sync_ready=1.
    tbl[0]  = mk(4'hF, 32'h13121110, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[1]  = mk(4'hF, 32'h13121110, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[2]  = mk(4'hF, 32'h13121110, 4'hF, 1'b0, 8'h00, 2'd0);
    tbl[3]  = mk(4'hF, 32'h13121110, 4'h0, 1'b1, 8'h10, 2'd0);
    tbl[4]  = mk(4'hF, 32'h13121110, 4'h0, 1'b1, 8'h11, 2'd1);
    tbl[5]  = mk(4'hF, 32'h13121110, 4'h0, 1'b1, 8'h12, 2'd2);
    tbl[6]  = mk(4'hF, 32'h13121110, 4'h0, 1'b1, 8'h13, 2'd3);
    tbl[7]  = mk(4'hF, 32'h13121110, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[8]  = mk(4'h0, 32'h13121110, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[9]  = mk(4'h0, 32'h13121110, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[10] = mk(4'hF, 32'h23222120, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[11] = mk(4'hF, 32'h23222120, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[12] = mk(4'hF, 32'h23222120, 4'hF, 1'b0, 8'h00, 2'd0);
    tbl[13] = mk(4'hF, 32'h23222120, 4'h0, 1'b1, 8'h20, 2'd0);
    tbl[14] = mk(4'hF, 32'h23222120, 4'h0, 1'b1, 8'h21, 2'd1);
    tbl[15] = mk(4'hF, 32'h23222120, 4'h0, 1'b1, 8'h22, 2'd2);
    tbl[16] = mk(4'hF, 32'h23222120, 4'h0, 1'b1, 8'h23, 2'd3);
    tbl[17] = mk(4'hF, 32'h23222120, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[18] = mk(4'h0, 32'h23222120, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[19] = mk(4'h0, 32'h23222120, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[20] = mk(4'h2, 32'h0000A500, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[21] = mk(4'h2, 32'h0000A500, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[22] = mk(4'h2, 32'h0000A500, 4'h2, 1'b0, 8'h00, 2'd0);
    tbl[23] = mk(4'h2, 32'h0000A500, 4'h0, 1'b1, 8'hA5, 2'd1);
    tbl[24] = mk(4'h2, 32'h0000A500, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[25] = mk(4'h0, 32'h0000A500, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[26] = mk(4'h0, 32'h0000A500, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[27] = mk(4'hF, 32'h33323130, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[28] = mk(4'hF, 32'h33323130, 4'h0, 1'b0, 8'h00, 2'd0);
    tbl[29] = mk(4'hF, 32'h33323130, 4'hF, 1'b0, 8'h00, 2'd0);
    tbl[30] = mk(4'hF, 32'h33323130, 4'h0, 1'b1, 8'h32, 2'd2);
    tbl[31] = mk(4'hF, 32'h33323130, 4'h0, 1'b1, 8'h33, 2'd3);
    tbl[32] = mk(4'hF, 32'h33323130, 4'h0, 1'b1, 8'h30, 2'd0);
    tbl[33] = mk(4'hF, 32'h33323130, 4'h0, 1'b1, 8'h31, 2'd1);
    tbl[34] = mk(4'hF, 32'h33323130, 4'h0, 1'b0, 8'h00, 2'd0);

    RST = 1'b1;
    ubus = 32'h0; en = 4'h0; clr = 4'h0; rdy = 1'b1;
    t_ubus = 32'h0; t_en = 4'h0; t_clr = 4'h0; t_rdy = 1'b1;
    #1;
    chk("reset pulse", 32'(pulse), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset bus", 32'(dbus), 32'h0);
    chk("reset ch", 32'(ch), 32'h0);
    chk("reset ovr", 32'(ovr), 32'h0);
    chk("reset tog valid", 32'(t_valid), 32'h0);
    tick(); tick();
    RST = 1'b0;

    // Toggle mode: 0->1 then, ten cycles later, 1->0 on ch0.
    t_en = 4'h1; t_ubus = 32'h00000011;
    tick(); tick(); tick();
    chk("tog pulse1", 32'(t_pulse), 32'h1);
    tick();
    chk("tog valid1", 32'(t_valid), 32'h1);
    chk("tog bus1", 32'(t_dbus), 32'h11);
    chk("tog ch1", 32'(t_ch), 32'h0);
    tick();
    chk("tog idle1", 32'(t_valid), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    t_en = 4'h0; t_ubus = 32'h00000022;
    tick(); tick(); tick();
    chk("tog pulse2", 32'(t_pulse), 32'h1);
    tick();
    chk("tog valid2", 32'(t_valid), 32'h1);
    chk("tog bus2", 32'(t_dbus), 32'h22);
    tick();
    chk("tog idle2", 32'(t_valid), 32'h0);
    chk("tog ovr", 32'(t_ovr), 32'h0);

    // Table-driven level-mode vectors.
    for (int i = 0; i < 35; i++) begin
      en = tbl[i].en; ubus = tbl[i].bus;
      tick();
      chk($sformatf("row%0d pulse", i), 32'(pulse), 32'(tbl[i].pulse));
      chk($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("row%0d bus", i), 32'(dbus), 32'(tbl[i].dbus));
        chk($sformatf("row%0d ch", i), 32'(ch), 32'(tbl[i].ch));
      end
      chk($sformatf("row%0d ovr", i), 32'(ovr), 32'h0);
    end

    // Stall with ch2 firing three times: 0x33 lands in the output register,
    // 0x3C pends, 0x44 overruns and is dropped.
    en = 4'h0;
    tick(); tick(); tick();
    rdy = 1'b0; en = 4'h4; ubus = 32'h00330000;
    for (int i = 0; i < 4; i++) tick();
    chk("stall valid", 32'(valid), 32'h1);
    chk("stall ch", 32'(ch), 32'h2);
    en = 4'h0;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall hold a", 32'(dbus), 32'h33); end
    en = 4'h4; ubus = 32'h003C0000;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall hold b", 32'(dbus), 32'h33); end
    en = 4'h0;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall hold c", 32'(dbus), 32'h33); end
    chk("stall no ovr yet", 32'(ovr), 32'h0);
    en = 4'h4; ubus = 32'h00440000;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall hold d", 32'(dbus), 32'h33); end
    chk("stall ovr set", 32'(ovr), 32'h4);
    en = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall hold e", 32'(dbus), 32'h33);
      chk("stall valid e", 32'(valid), 32'h1);
    end
    rdy = 1'b1;
    tick();
    chk("release valid", 32'(valid), 32'h1);
    chk("release bus", 32'(dbus), 32'h3C);
    for (int i = 0; i < 4; i++) begin tick(); chk("no dropped word", 32'(valid), 32'h0); end
    chk("ovr sticky", 32'(ovr), 32'h4);
    clr = 4'h4;
    tick();
    clr = 4'h0;
    chk("ovr cleared", 32'(ovr), 32'h0);

    // Reset with a word in the output register and two channels pending.
    rdy = 1'b0; en = 4'hB; ubus = 32'h73007170;
    for (int i = 0; i < 4; i++) tick();
    chk("pre-rst valid", 32'(valid), 32'h1);
    chk("pre-rst ch", 32'(ch), 32'h3);
    chk("pre-rst bus", 32'(dbus), 32'h73);
    #2;
    RST = 1'b1;
    #1;
    chk("mid-rst valid", 32'(valid), 32'h0);
    chk("mid-rst bus", 32'(dbus), 32'h0);
    chk("mid-rst ch", 32'(ch), 32'h0);
    chk("mid-rst pulse", 32'(pulse), 32'h0);
    en = 4'h0;
    tick(); tick();
    RST = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post-rst valid", 32'(valid), 32'h0);
      chk("post-rst pulse", 32'(pulse), 32'h0);
    end

    // ch3 event arriving at the same edge ch3 is granted.
    rdy = 1'b0; en = 4'h1; ubus = 32'h00000050;
    for (int i = 0; i < 4; i++) tick();
    chk("busy ch0", 32'(dbus), 32'h50);
    en = 4'h8; ubus = 32'h61000000;
    tick(); tick(); tick();
    en = 4'h0;
    tick(); tick(); tick();
    en = 4'h8; ubus = 32'h62000000;
    tick(); tick();
    rdy = 1'b1;
    tick();
    chk("same-edge pulse", 32'(pulse), 32'h8);
    chk("same-edge bus1", 32'(dbus), 32'h61);
    chk("same-edge ch1", 32'(ch), 32'h3);
    tick();
    chk("same-edge valid2", 32'(valid), 32'h1);
    chk("same-edge bus2", 32'(dbus), 32'h62);
    chk("same-edge ch2", 32'(ch), 32'h3);
    tick();
    chk("same-edge idle", 32'(valid), 32'h0);
    chk("same-edge ovr", 32'(ovr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
